alarm_time_entry: RTL and testbench



---
 rtl/alarm_time_entry_pkg.sv | 43 ++++
 rtl/alarm_time_entry_btn_debounce.sv | 51 +++++
 rtl/alarm_time_entry.sv | 161 ++++++++++++++++
 tb/tb_alarm_time_entry.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_time_entry_pkg.sv
// alarm_time_entry_pkg
// Shared definitions for the alarm time-entry front-end:
//   - FSM state encoding
//   - BCD digit constants and the range limits for the minute and hour pairs
//   - helpers that map a state to its output flags and a binary value to two BCD digits
package alarm_time_entry_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SET_HOURS   = 2'd1,
    ST_SET_MINUTES = 2'd2,
    ST_ARMED       = 2'd3
  } state_t;

  localparam logic [3:0] BCD_0 = 4'd0;
  localparam logic [3:0] BCD_2 = 4'd2;
  localparam logic [3:0] BCD_5 = 4'd5;
  localparam logic [3:0] BCD_9 = 4'd9;

  localparam logic [7:0] MINUTE_MAX = {BCD_5, BCD_9};
  localparam logic [7:0] HOUR_MAX   = {BCD_2, 4'd3};

  typedef struct packed {
    logic alarm_enable;
    logic armed;
    logic sel_hours;
    logic sel_minutes;
  } flags_t;

  function automatic flags_t state_flags(input state_t s);
    flags_t f;
    f.alarm_enable = (s == ST_SET_HOURS) || (s == ST_SET_MINUTES);
    f.armed        = (s == ST_ARMED);
    f.sel_hours    = (s == ST_SET_HOURS);
    f.sel_minutes  = (s == ST_SET_MINUTES);
    return f;
  endfunction

  function automatic logic [7:0] to_bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/alarm_time_entry_btn_debounce.sv
// btn_debounce
// Two-flop synchroniser followed by a down-counting debouncer for one raw button.
// The stable level only moves after the synchronised input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle reloads the counter.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   btn_raw     raw asynchronous button input (active-high)
//   level       debounced button level
//   press       one-cycle pulse on the debounced 0->1 transition
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      press   <= 1'b0;
      cnt     <= RELOAD;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        // terminal count: the new level has held long enough
        level <= sync_q2;
        press <= sync_q2;
        cnt   <= RELOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_time_entry.sv
// alarm_time_entry
// Turns four raw push-buttons into a BCD hours:minutes duration plus an enable
// level for the alarm countdown stage. The countdown copies the digits when
// alarm_enable falls.
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   btn_mode/up/down/start        raw async buttons (active-high)
//   h_msb, h_lsb, m_msb, m_lsb    registered BCD digits
//   alarm_enable                  high while editing
//   armed                         high in ARMED
//   sel_hours, sel_minutes        selected edit field
//
// state          | meaning
// ST_IDLE        | after reset, waiting for mode
// ST_SET_HOURS   | editing hours, alarm_enable high
// ST_SET_MINUTES | editing minutes, alarm_enable high
// ST_ARMED       | duration handed off, digits frozen
module alarm_time_entry
  import alarm_time_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_HOURS       = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [3:0] h_msb,
  output logic [3:0] h_lsb,
  output logic [3:0] m_msb,
  output logic [3:0] m_lsb,
  output logic       alarm_enable,
  output logic       armed,
  output logic       sel_hours,
  output logic       sel_minutes
);

  localparam logic [7:0] HOUR_MAX_BCD = to_bcd2(MAX_HOURS);

  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic       unused_levels;

  assign btn_raw       = {btn_start, btn_mode, btn_up, btn_down};
  assign unused_levels = ^btn_level;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i])
    );
  end

  logic p_start, p_mode, p_up, p_down, p_step;
  assign p_start = btn_press[3];
  assign p_mode  = btn_press[2];
  assign p_up    = btn_press[1];
  assign p_down  = btn_press[0];
  // up and down in the same cycle cancel
  assign p_step  = p_up ^ p_down;

  // BCD +-1 on a two-digit pair wrapping between 00 and max
  function automatic logic [7:0] bcd_step(input logic [7:0] cur, input logic up,
                                          input logic [7:0] max);
    if (up) begin
      if (cur == max)           return 8'h00;
      else if (cur[3:0] == BCD_9) return {cur[7:4] + 4'd1, BCD_0};
      else                      return {cur[7:4], cur[3:0] + 4'd1};
    end else begin
      if (cur == 8'h00)         return max;
      else if (cur[3:0] == BCD_0) return {cur[7:4] - 4'd1, BCD_9};
      else                      return {cur[7:4], cur[3:0] - 4'd1};
    end
  endfunction

  function automatic logic [7:0] hours_step(input logic [7:0] cur, input logic up);
    return bcd_step(cur, up, HOUR_MAX_BCD);
  endfunction

  function automatic logic [7:0] minutes_step(input logic [7:0] cur, input logic up);
    return bcd_step(cur, up, MINUTE_MAX);
  endfunction

  state_t     state;
  flags_t     flags;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic       nonzero;

  assign nonzero = (hours != 8'h00) || (minutes != 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      flags   <= state_flags(ST_IDLE);
      hours   <= 8'h00;
      minutes <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!p_start && p_mode) begin
            state <= ST_SET_HOURS;
            flags <= state_flags(ST_SET_HOURS);
          end
        end
        ST_SET_HOURS: begin
          if (p_start) begin
            if (nonzero) begin
              state <= ST_ARMED;
              flags <= state_flags(ST_ARMED);
            end
          end else if (p_mode) begin
            state <= ST_SET_MINUTES;
            flags <= state_flags(ST_SET_MINUTES);
          end else if (p_step) begin
            hours <= hours_step(hours, p_up);
          end
        end
        ST_SET_MINUTES: begin
          if (p_start) begin
            if (nonzero) begin
              state <= ST_ARMED;
              flags <= state_flags(ST_ARMED);
            end
          end else if (p_mode) begin
            state <= ST_SET_HOURS;
            flags <= state_flags(ST_SET_HOURS);
          end else if (p_step) begin
            minutes <= minutes_step(minutes, p_up);
          end
        end
        ST_ARMED: begin
          if (!p_start && p_mode) begin
            state <= ST_SET_HOURS;
            flags <= state_flags(ST_SET_HOURS);
          end
        end
        default: begin
          state <= ST_IDLE;
          flags <= state_flags(ST_IDLE);
        end
      endcase
    end
  end

  assign h_msb        = hours[7:4];
  assign h_lsb        = hours[3:0];
  assign m_msb        = minutes[7:4];
  assign m_lsb        = minutes[3:0];
  assign alarm_enable = flags.alarm_enable;
  assign armed        = flags.armed;
  assign sel_hours    = flags.sel_hours;
  assign sel_minutes  = flags.sel_minutes;

endmodule

// File: tb/tb_alarm_time_entry.sv
// Testbench for alarm_time_entry with a short debounce window.
module tb_alarm_time_entry;

  localparam int DB   = 4;
  localparam int MAXH = 23;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
  logic [3:0] h_msb, h_lsb, m_msb, m_lsb;
  logic alarm_enable, armed, sel_hours, sel_minutes;

  int compared = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alarm_time_entry #(.DEBOUNCE_CYCLES(DB), .MAX_HOURS(MAXH)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
    .h_msb(h_msb), .h_lsb(h_lsb), .m_msb(m_msb), .m_lsb(m_lsb),
    .alarm_enable(alarm_enable), .armed(armed),
    .sel_hours(sel_hours), .sel_minutes(sel_minutes)
  );

  wire [19:0] dut_vec = {h_msb, h_lsb, m_msb, m_lsb,
                         alarm_enable, armed, sel_hours, sel_minutes};

  // reference model: duration as plain integers, mode as an abstract phase
  typedef enum {M_IDLE, M_HOURS, M_MINUTES, M_ARMED} mphase_t;
  mphase_t mp = M_IDLE;
  int mh = 0;
  int mm = 0;

  function automatic logic [19:0] model_vec(input mphase_t p, input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            (p == M_HOURS || p == M_MINUTES), (p == M_ARMED),
            (p == M_HOURS), (p == M_MINUTES)};
  endfunction

  // mask = {start, mode, up, down}
  task automatic model_apply(input logic [3:0] mask);
    logic s, md, u, d;
    {s, md, u, d} = mask;
    case (mp)
      M_IDLE:  if (!s && md) mp = M_HOURS;
      M_ARMED: if (!s && md) mp = M_HOURS;
      M_HOURS, M_MINUTES: begin
        if (s) begin
          if (mh != 0 || mm != 0) mp = M_ARMED;
        end else if (md) begin
          mp = (mp == M_HOURS) ? M_MINUTES : M_HOURS;
        end else if (u && !d) begin
          if (mp == M_HOURS) mh = (mh + 1) % (MAXH + 1);
          else               mm = (mm + 1) % 60;
        end else if (d && !u) begin
          if (mp == M_HOURS) mh = (mh + MAXH) % (MAXH + 1);
          else               mm = (mm + 59) % 60;
        end
      end
      default: mp = M_IDLE;
    endcase
  endtask

  task automatic model_reset();
    mp = M_IDLE; mh = 0; mm = 0;
  endtask

  task automatic press(input logic [3:0] mask);
    {btn_start, btn_mode, btn_up, btn_down} = mask;
    repeat (10) @(negedge clk);
    {btn_start, btn_mode, btn_up, btn_down} = 4'b0000;
    repeat (10) @(negedge clk);
    model_apply(mask);
  endtask

  task automatic press_n(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) press(mask);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (100) @(negedge clk);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm)) begin
      failed++;
      $display("FAIL reset_idle: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    press(4'b0010);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm)) begin
      failed++;
      $display("FAIL up_in_idle: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
  endtask

  task automatic test_hours();
    press(4'b0100);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm)) begin
      failed++;
      $display("FAIL enter_hours: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    for (int i = 0; i < 10; i++) begin
      press(4'b0010);
      compared++;
      if (dut_vec !== model_vec(mp, mh, mm)) begin
        failed++;
        $display("FAIL hours_up step %0d: got %h expected %h", i, dut_vec, model_vec(mp, mh, mm));
      end
    end
    for (int i = 0; i < 11; i++) begin
      press(4'b0001);
      compared++;
      if (dut_vec !== model_vec(mp, mh, mm)) begin
        failed++;
        $display("FAIL hours_down step %0d: got %h expected %h", i, dut_vec, model_vec(mp, mh, mm));
      end
    end
    compared++;
    if ({h_msb, h_lsb} !== 8'h23) begin
      failed++;
      $display("FAIL hours_wrap_23: got %h expected 23", {h_msb, h_lsb});
    end
  endtask

  task automatic test_minutes();
    press(4'b0100);
    press(4'b0001);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm) || {m_msb, m_lsb} !== 8'h59) begin
      failed++;
      $display("FAIL minutes_wrap_59: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    press(4'b0010);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm) || {m_msb, m_lsb} !== 8'h00) begin
      failed++;
      $display("FAIL minutes_wrap_00: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    press_n(4'b0010, 10);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm) || {m_msb, m_lsb} !== 8'h10) begin
      failed++;
      $display("FAIL minutes_carry_10: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
  endtask

  task automatic test_start();
    bit seen;
    logic armed_at_fall;
    logic [15:0] digits_at_fall;
    // drive to 00:00 while in minutes
    press(4'b0100);
    press(4'b0010);
    press(4'b0100);
    press_n(4'b0001, 10);
    press(4'b1000);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm) || alarm_enable !== 1'b1 || sel_minutes !== 1'b1) begin
      failed++;
      $display("FAIL start_at_zero: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    // set 01:30
    press(4'b0100);
    press(4'b0010);
    press(4'b0100);
    press_n(4'b0010, 30);
    compared++;
    if (alarm_enable !== 1'b1) begin
      failed++;
      $display("FAIL enable_before_start: got %b expected 1", alarm_enable);
    end
    seen = 0;
    armed_at_fall = 1'b0;
    digits_at_fall = 16'h0;
    btn_start = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (alarm_enable === 1'b0) begin
        seen = 1;
        armed_at_fall = armed;
        digits_at_fall = {h_msb, h_lsb, m_msb, m_lsb};
      end
    end
    btn_start = 1'b0;
    repeat (10) @(negedge clk);
    model_apply(4'b1000);
    compared++;
    if (!seen || armed_at_fall !== 1'b1 || digits_at_fall !== 16'h0130) begin
      failed++;
      $display("FAIL arm_handoff: fell=%0d armed=%b digits=%h expected fell=1 armed=1 digits=0130",
               seen, armed_at_fall, digits_at_fall);
    end
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm)) begin
      failed++;
      $display("FAIL armed_state: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
  endtask

  task automatic test_bounce();
    press(4'b0100);
    for (int i = 0; i < 5; i++) begin
      btn_up = 1'b1;
      repeat (3) @(negedge clk);
      btn_up = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm)) begin
      failed++;
      $display("FAIL bounce_no_event: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    press(4'b0010);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm) || {h_msb, h_lsb} !== 8'h02) begin
      failed++;
      $display("FAIL bounce_then_clean: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    press(4'b0011);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm)) begin
      failed++;
      $display("FAIL up_down_together: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
  endtask

  task automatic test_armed_reset();
    press_n(4'b0010, 10);
    press(4'b0100);
    press_n(4'b0010, 15);
    press(4'b1000);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm) || {h_msb, h_lsb, m_msb, m_lsb} !== 16'h1245) begin
      failed++;
      $display("FAIL armed_1245: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    press(4'b0100);
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm) || alarm_enable !== 1'b1) begin
      failed++;
      $display("FAIL rearm_edit_retained: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    press(4'b1000);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    compared++;
    if (dut_vec !== model_vec(mp, mh, mm)) begin
      failed++;
      $display("FAIL reset_in_armed: got %h expected %h", dut_vec, model_vec(mp, mh, mm));
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] mask;
    for (int i = 0; i < 80; i++) begin
      // bias towards single-button presses, with occasional combinations
      if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(1, 15));
      else                            mask = 4'b0001 << $urandom_range(0, 3);
      press(mask);
      compared++;
      if (dut_vec !== model_vec(mp, mh, mm)) begin
        failed++;
        $display("FAIL random step %0d mask %b: got %h expected %h",
                 i, mask, dut_vec, model_vec(mp, mh, mm));
      end
    end
  endtask

  initial begin
    test_reset();
    test_hours();
    test_minutes();
    test_start();
    test_bounce();
    test_armed_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
